// File: rtl/vg_timing_gen.sv
// -----------------------------------------------------------------------------
// vg_timing_gen
// Free-running video timing generator for the oscilloscope display path.
// A horizontal/vertical counter pair walks the raster (sync, back porch,
// active, front porch in both directions). Every output is decoded from the
// counter values and registered in a single stage, so all outputs are exactly
// cycle-aligned with one another and lag the counters by one cycle.
//
// Ports
//   pix_clk     in   1        pixel clock, the only clock of the block
//   rst         in   1        asynchronous active-high reset
//   en          in   1        run enable; low holds the restart state
//   hs_out      out  1        horizontal sync, active level HS_POL
//   vs_out      out  1        vertical sync, active level VS_POL
//   de_out      out  1        data enable, high in the active area only
//   act_x       out  X_BITS   active column, 0 outside the active area
//   act_y       out  Y_BITS   active row, 0 outside the active area
//   frame_start out  1        pulse on the output cycle for (h=0, v=0)
//   line_start  out  1        pulse on the output cycle for h=0
//
// H_TOTAL must not exceed 2**X_BITS and V_TOTAL must not exceed 2**Y_BITS.
// -----------------------------------------------------------------------------
module vg_timing_gen #(
    parameter int X_BITS = 13,
    parameter int Y_BITS = 13,
    parameter int H_SYNC = 44,
    parameter int H_BP   = 148,
    parameter int H_ACT  = 1920,
    parameter int H_FP   = 88,
    parameter int V_SYNC = 5,
    parameter int V_BP   = 36,
    parameter int V_ACT  = 1080,
    parameter int V_FP   = 4,
    parameter bit HS_POL = 1'b1,
    parameter bit VS_POL = 1'b1
) (
    input  logic              pix_clk,
    input  logic              rst,
    input  logic              en,
    output logic              hs_out,
    output logic              vs_out,
    output logic              de_out,
    output logic [X_BITS-1:0] act_x,
    output logic [Y_BITS-1:0] act_y,
    output logic              frame_start,
    output logic              line_start
);

    localparam int H_TOTAL = H_SYNC + H_BP + H_ACT + H_FP;
    localparam int V_TOTAL = V_SYNC + V_BP + V_ACT + V_FP;

    // Window bounds are held one bit wider than the counters: with a zero
    // front porch and a full-range total, the end of the active window equals
    // 2**X_BITS and would otherwise wrap to zero.
    localparam logic [X_BITS:0]   H_SYNC_END = (X_BITS+1)'(H_SYNC);
    localparam logic [X_BITS:0]   H_ACT_BEG  = (X_BITS+1)'(H_SYNC + H_BP);
    localparam logic [X_BITS:0]   H_ACT_END  = (X_BITS+1)'(H_SYNC + H_BP + H_ACT);
    localparam logic [Y_BITS:0]   V_SYNC_END = (Y_BITS+1)'(V_SYNC);
    localparam logic [Y_BITS:0]   V_ACT_BEG  = (Y_BITS+1)'(V_SYNC + V_BP);
    localparam logic [Y_BITS:0]   V_ACT_END  = (Y_BITS+1)'(V_SYNC + V_BP + V_ACT);

    localparam logic [X_BITS-1:0] H_LAST     = X_BITS'(H_TOTAL - 1);
    localparam logic [Y_BITS-1:0] V_LAST     = Y_BITS'(V_TOTAL - 1);
    localparam logic [X_BITS-1:0] H_OFS      = X_BITS'(H_SYNC + H_BP);
    localparam logic [Y_BITS-1:0] V_OFS      = Y_BITS'(V_SYNC + V_BP);

    localparam logic HS_IDLE = ~HS_POL;
    localparam logic VS_IDLE = ~VS_POL;

    // Raster position counters
    logic [X_BITS-1:0] h_q;
    logic [X_BITS-1:0] h_d;
    logic [Y_BITS-1:0] v_q;
    logic [Y_BITS-1:0] v_d;

    // Next-state of the output register stage
    logic              hs_d;
    logic              vs_d;
    logic              de_d;
    logic [X_BITS-1:0] act_x_d;
    logic [Y_BITS-1:0] act_y_d;
    logic              frame_start_d;
    logic              line_start_d;

    // Zero-extended copies for comparison against the widened window bounds
    logic [X_BITS:0]   h_ext_s;
    logic [Y_BITS:0]   v_ext_s;
    logic              h_act_s;
    logic              v_act_s;

    assign h_ext_s = {1'b0, h_q};
    assign v_ext_s = {1'b0, v_q};
    assign h_act_s = (h_ext_s >= H_ACT_BEG) && (h_ext_s < H_ACT_END);
    assign v_act_s = (v_ext_s >= V_ACT_BEG) && (v_ext_s < V_ACT_END);

    // Counter advance and output decode of the current position
    always_comb begin
        h_d           = {X_BITS{1'b0}};
        v_d           = {Y_BITS{1'b0}};
        hs_d          = HS_IDLE;
        vs_d          = VS_IDLE;
        de_d          = 1'b0;
        act_x_d       = {X_BITS{1'b0}};
        act_y_d       = {Y_BITS{1'b0}};
        frame_start_d = 1'b0;
        line_start_d  = 1'b0;

        if (en) begin
            // Vertical counter only moves on the horizontal wrap
            if (h_q == H_LAST) begin
                h_d = {X_BITS{1'b0}};
                if (v_q == V_LAST) begin
                    v_d = {Y_BITS{1'b0}};
                end else begin
                    v_d = v_q + {{(Y_BITS-1){1'b0}}, 1'b1};
                end
            end else begin
                h_d = h_q + {{(X_BITS-1){1'b0}}, 1'b1};
                v_d = v_q;
            end

            hs_d          = (h_ext_s < H_SYNC_END) ? HS_POL : HS_IDLE;
            vs_d          = (v_ext_s < V_SYNC_END) ? VS_POL : VS_IDLE;
            de_d          = h_act_s && v_act_s;
            line_start_d  = (h_q == {X_BITS{1'b0}});
            frame_start_d = (h_q == {X_BITS{1'b0}}) && (v_q == {Y_BITS{1'b0}});

            if (h_act_s && v_act_s) begin
                act_x_d = h_q - H_OFS;
                act_y_d = v_q - V_OFS;
            end else begin
                act_x_d = {X_BITS{1'b0}};
                act_y_d = {Y_BITS{1'b0}};
            end
        end else begin
            // Disabled: counters parked at the origin, outputs idle, so the
            // first enabled edge registers position (0, 0).
            h_d = {X_BITS{1'b0}};
            v_d = {Y_BITS{1'b0}};
        end
    end

    // Counter and output register stage
    always_ff @(posedge pix_clk or posedge rst) begin
        if (rst) begin
            h_q         <= {X_BITS{1'b0}};
            v_q         <= {Y_BITS{1'b0}};
            hs_out      <= HS_IDLE;
            vs_out      <= VS_IDLE;
            de_out      <= 1'b0;
            act_x       <= {X_BITS{1'b0}};
            act_y       <= {Y_BITS{1'b0}};
            frame_start <= 1'b0;
            line_start  <= 1'b0;
        end else begin
            h_q         <= h_d;
            v_q         <= v_d;
            hs_out      <= hs_d;
            vs_out      <= vs_d;
            de_out      <= de_d;
            act_x       <= act_x_d;
            act_y       <= act_y_d;
            frame_start <= frame_start_d;
            line_start  <= line_start_d;
        end
    end

endmodule

// File: doc/vg_timing_gen.md
# vg_timing_gen

Video timing generator for the oscilloscope display path. It runs free on the pixel clock and produces the `hs_out`, `vs_out` and `de_out` syncs together with active-area coordinates `act_x` and `act_y`. These outputs connect directly to the grid/pattern stage's `hs_in`, `vs_in`, `de_in`, `act_x` and `act_y` inputs. All outputs are registered and mutually cycle-aligned, so the downstream stage can use them without extra delay matching.

## Interface
Parameters:
- `X_BITS`, default 13: width of the horizontal counter and `act_x`.
- `Y_BITS`, default 13: width of the vertical counter and `act_y`.
- `H_SYNC` / `H_BP` / `H_ACT` / `H_FP`, default 44 / 148 / 1920 / 88: horizontal segment lengths in pixels. `H_TOTAL` = 2200.
- `V_SYNC` / `V_BP` / `V_ACT` / `V_FP`, default 5 / 36 / 1080 / 4: vertical segment lengths in lines. `V_TOTAL` = 1125.
- `HS_POL`, default 1: active level of `hs_out`.
- `VS_POL`, default 1: active level of `vs_out`.

Ports:
- `pix_clk`, in, 1: pixel clock. This is the only clock in the block.
- `rst`, in, 1: reset, asynchronous, active-high.
- `en`, in, 1: run enable. While low, the block holds the restart state.
- `hs_out`, out, 1: horizontal sync.
- `vs_out`, out, 1: vertical sync.
- `de_out`, out, 1: data enable, high in the active area only.
- `act_x`, out, `X_BITS`: active column 0..`H_ACT`-1; reads 0 outside the active area.
- `act_y`, out, `Y_BITS`: active row 0..`V_ACT`-1; reads 0 outside the active area.
- `frame_start`, out, 1: one-cycle pulse coinciding with the output cycle for position (h=0, v=0).
- `line_start`, out, 1: one-cycle pulse coinciding with the output cycle for h=0, on every line.

## Operation
- **Internal counters**
  - `h_cnt` counts 0..`H_TOTAL`-1 and then wraps to 0.
  - `v_cnt` increments only when `h_cnt` wraps. It counts 0..`V_TOTAL`-1 and then wraps to 0.
- **Segment order within a line or frame:** sync, back porch, active, front porch.
- **Output decode from the counters (h, v)**
  - `hs_out` is at the active level when h < `H_SYNC`, otherwise at the inactive level.
  - `vs_out` is at the active level when v < `V_SYNC`, otherwise at the inactive level. Because it is decoded from `v_cnt`, its edges fall on h=0 boundaries only.
  - `de_out` = (`H_SYNC`+`H_BP` ≤ h < `H_SYNC`+`H_BP`+`H_ACT`) AND (`V_SYNC`+`V_BP` ≤ v < `V_SYNC`+`V_BP`+`V_ACT`).
  - When `de_out` would be high, `act_x` = h − (`H_SYNC`+`H_BP`) and `act_y` = v − (`V_SYNC`+`V_BP`). Otherwise both read 0.
- **Arithmetic and widths**
  - All comparisons are unsigned.
  - `H_TOTAL` must be ≤ 2^`X_BITS` and `V_TOTAL` must be ≤ 2^`Y_BITS`.
  - Subtraction results are truncated to the port width; no overflow is possible with legal parameters.
- **Enable behaviour**
  - While `en` = 0, the counters are forced to 0 and every output is held at its reset value.
  - On the first edge with `en` = 1, the outputs register position (0, 0). A new frame therefore always begins cleanly.
  - Dropping `en` mid-frame aborts the frame: on the next edge the outputs return to their reset values.

## Timing
- **Reset values** (while `rst` is high, applied asynchronously):
  - `h_cnt` = 0, `v_cnt` = 0.
  - `hs_out` = ~`HS_POL`, `vs_out` = ~`VS_POL`.
  - `de_out` = 0, `act_x` = 0, `act_y` = 0, `frame_start` = 0, `line_start` = 0.
- **Latency:** one cycle. If the counters hold (h, v) during cycle n, every output reflects (h, v) during cycle n+1.
- **Alignment:** all outputs come from the same register stage, so they are exactly aligned with one another.
- **Reset release:** the first edge with `rst` = 0 and `en` = 1 registers position (0, 0):
  - `hs_out` and `vs_out` go active.
  - `frame_start` = 1 and `line_start` = 1.
  - The counters advance to (1, 0).
- **Wrap:** the output cycle for (`H_TOTAL`-1, `V_TOTAL`-1) is followed immediately by the output cycle for (0, 0). There is no idle gap.
- **Period:** `de_out` high time per line is exactly `H_ACT` cycles, and the frame period is `H_TOTAL`×`V_TOTAL` cycles.
- **Simultaneous `rst` and `en`:** `rst` dominates.

## Test plan
The bench uses small parameters: H = 2/2/8/2 (`H_TOTAL` = 14), V = 1/1/4/1 (`V_TOTAL` = 7), `HS_POL` = `VS_POL` = 1.

1. **Reset:** hold `rst` high for 5 cycles with `en` = 1 → `hs_out` = `vs_out` = `de_out` = 0, `act_x` = `act_y` = 0, no pulses. The first edge after release gives `hs_out` = 1, `vs_out` = 1, `frame_start` = 1.
2. **Horizontal timing:** over one line → `hs_out` is high for 2 cycles and `de_out` is high for exactly 8 cycles starting 4 cycles after `line_start`. During those 8 cycles `act_x` steps 0..7 and is 0 elsewhere; `line_start` repeats every 14 cycles.
3. **Vertical timing:** over one frame (98 cycles) → `vs_out` is high for 14 cycles, and `de_out` appears on 4 lines (lines 2..5) with `act_y` = 0..3. The frame contains 32 `de_out` cycles in total.
4. **Wrap:** run 3 frames → `frame_start` fires at cycles 0, 98 and 196 exactly. The output for (13, 6) is followed directly by the output for (0, 0).
5. **Enable abort:** drop `en` at cycle 50 of a frame for 10 cycles → outputs hold their reset values from the next edge. When `en` rises, the next edge gives `frame_start` = 1 and the full frame repeats.
6. **Asynchronous reset mid-line:** assert `rst` between clock edges while `de_out` = 1 → `de_out`, `act_x` and `act_y` clear immediately, without waiting for a clock edge. Recovery after release is the same as scenario 1.
